// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep driver.
// Vector geometry, FSM state encoding and the lab function's golden table.
package tt_pkg;

    localparam int VEC_W = 4;
    localparam int N_VEC = 16;

    // Golden truth table of the lab function; bit i = y for {a,b,c,d} = i.
    localparam logic [N_VEC-1:0] LAB_FN_EXPECTED = 16'hA7FF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } tt_state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counting settle timer: load arms it, en runs it, expired flags the last cycle.
// Ports: clk, rst_n (async active-low), load, en -> expired.
module tt_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Loaded with N-1 so that expired rises in the N-th enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/tt_sweep_driver.sv
// Sweeps all 16 {a,b,c,d} vectors into a 4-input function, samples y, and grades the table.
// Ports: clk, rst_n, start, abort, y -> a,b,c,d, busy, done, pass, table_o, mismatch_cnt, first_fail, fail_valid.
module tt_sweep_driver
    import tt_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 2,
    parameter logic [N_VEC-1:0] EXPECTED      = LAB_FN_EXPECTED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_VEC-1:0] table_o,
    output logic [4:0]       mismatch_cnt,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_valid
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end

    tt_state_e        state, state_n;
    logic [VEC_W-1:0] idx, idx_n;
    logic [VEC_W-1:0] vec, vec_n;
    logic             busy_n, done_n, pass_n, fv_n;
    logic [N_VEC-1:0] tbl_n;
    logic [4:0]       mc_n;
    logic [VEC_W-1:0] ff_n;
    logic             t_load, t_en, t_exp;
    logic             miss;

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (t_load),
        .en     (t_en),
        .expired(t_exp)
    );

    assign miss = (y != EXPECTED[idx]);

    // Every output flop is computed for the state being entered, so
    // the vector, busy, done and pass all line up with that state.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        vec_n   = vec;
        busy_n  = busy;
        done_n  = 1'b0;
        pass_n  = pass;
        tbl_n   = table_o;
        mc_n    = mismatch_cnt;
        ff_n    = first_fail;
        fv_n    = fail_valid;
        t_load  = 1'b0;
        t_en    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETTLE;
                    idx_n   = '0;
                    vec_n   = '0;
                    busy_n  = 1'b1;
                    tbl_n   = '0;
                    mc_n    = '0;
                    ff_n    = '0;
                    fv_n    = 1'b0;
                    pass_n  = 1'b0;
                    t_load  = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_n = IDLE;
                    vec_n   = '0;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                end else begin
                    t_en = 1'b1;
                    if (t_exp) begin
                        state_n = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (abort) begin
                    // Aborted sample is dropped; partial results stay.
                    state_n = IDLE;
                    vec_n   = '0;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                end else begin
                    tbl_n[idx] = y;
                    if (miss) begin
                        mc_n = mismatch_cnt + 5'd1;
                        if (!fail_valid) begin
                            ff_n = idx;
                            fv_n = 1'b1;
                        end
                    end
                    if (idx == VEC_W'(N_VEC - 1)) begin
                        state_n = DONE;
                        vec_n   = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (mc_n == 5'd0);
                    end else begin
                        state_n = SETTLE;
                        idx_n   = idx + 1'b1;
                        vec_n   = idx + 1'b1;
                        t_load  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            vec          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            table_o      <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_valid   <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            vec          <= vec_n;
            busy         <= busy_n;
            done         <= done_n;
            pass         <= pass_n;
            table_o      <= tbl_n;
            mismatch_cnt <= mc_n;
            first_fail   <= ff_n;
            fail_valid   <= fv_n;
        end
    end

    assign {a, b, c, d} = vec;

endmodule
